// File: rtl/capp_pkg.sv
// ============================================================================
// capp_pkg : shared types and defaults for the CAPP multiple-response resolver
// Revision : 1.0
// ============================================================================
`default_nettype none

package capp_pkg;

    localparam int CAPP_NWORDS = 100;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_AND   = 2'b10,
        CMD_ENUM  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAMPLE = 2'b01,
        ST_ENUM   = 2'b10
    } state_e;

endpackage : capp_pkg

`default_nettype wire

// File: rtl/capp_prio_enc.sv
// ============================================================================
// capp_prio_enc : combinational lowest-set-bit encoder with found flag
// Revision      : 1.0
// ============================================================================
`default_nettype none

module capp_prio_enc #(
    parameter int N     = 100,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan high to low so the last hit written is the lowest index.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign found = |vec;

endmodule : capp_prio_enc

`default_nettype wire

// File: rtl/capp_response_resolver.sv
// ============================================================================
// capp_response_resolver : responder tag register with LOAD/AND intersection
//                          and destructive lowest-first enumeration stream.
// Optional: CAPP_RESP_COUNT_EN adds the resp_count popcount register/port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module capp_response_resolver
    import capp_pkg::*;
#(
    parameter int NWORDS = CAPP_NWORDS,
    parameter int IDX_W  = $clog2(NWORDS),
    parameter int CNT_W  = $clog2(NWORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWORDS-1:0] mismatch_lines,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    output logic              cmd_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic              done,
    output logic              any_resp,
    output logic [IDX_W-1:0]  first_idx
`ifdef CAPP_RESP_COUNT_EN
    ,
    output logic [CNT_W-1:0]  resp_count
`endif
);

    localparam logic [NWORDS-1:0] LSB_ONE = {{(NWORDS-1){1'b0}}, 1'b1};

    state_e              state, state_nxt;
    logic                op_and, op_and_nxt;
    logic [NWORDS-1:0]   tags, tags_nxt;
    logic [IDX_W-1:0]    low_idx;
    logic                low_found;

    capp_prio_enc #(
        .N     (NWORDS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec   (tags),
        .idx   (low_idx),
        .found (low_found)
    );

    assign out_idx   = low_idx;
    assign first_idx = low_idx;
    assign any_resp  = low_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_and <= 1'b0;
            tags   <= '0;
        end else begin
            state  <= state_nxt;
            op_and <= op_and_nxt;
            tags   <= tags_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_and_nxt = op_and;
        tags_nxt   = tags;
        cmd_ready  = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_e'(cmd))
                        CMD_CLEAR: tags_nxt = '0;
                        CMD_LOAD: begin
                            state_nxt  = ST_SAMPLE;
                            op_and_nxt = 1'b0;
                        end
                        CMD_AND: begin
                            state_nxt  = ST_SAMPLE;
                            op_and_nxt = 1'b1;
                        end
                        CMD_ENUM:  state_nxt = ST_ENUM;
                        default:   state_nxt = ST_IDLE;
                    endcase
                end
            end

            // Cell array compare has settled by the end of this cycle.
            ST_SAMPLE: begin
                tags_nxt  = op_and ? (tags & ~mismatch_lines) : ~mismatch_lines;
                state_nxt = ST_IDLE;
            end

            ST_ENUM: begin
                if (low_found) begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        // x & (x-1) drops exactly the lowest set bit.
                        tags_nxt = tags & (tags - LSB_ONE);
                    end
                end else begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef CAPP_RESP_COUNT_EN
    logic [CNT_W-1:0] cnt, cnt_nxt, pop_nxt;

    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < NWORDS; i++) begin
            pop_nxt = pop_nxt + CNT_W'(tags_nxt[i]);
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state == ST_SAMPLE) begin
            cnt_nxt = pop_nxt;
        end else if (out_valid && out_ready) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else if ((state == ST_IDLE) && cmd_valid && (cmd_e'(cmd) == CMD_CLEAR)) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign resp_count = cnt;
`endif

endmodule : capp_response_resolver

`default_nettype wire

// File: tb/tb_capp_response_resolver.sv
// ============================================================================
// tb_capp_response_resolver : randomized self-checking bench for the resolver
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_capp_response_resolver;
    import capp_pkg::*;

    localparam int N  = 100;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  mismatch_lines;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic          cmd_ready;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic          out_ready;
    logic          done;
    logic          any_resp;
    logic [IW-1:0] first_idx;
`ifdef CAPP_RESP_COUNT_EN
    logic [6:0]    resp_count;
`endif

    capp_response_resolver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mismatch_lines (mismatch_lines),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .cmd_ready      (cmd_ready),
        .out_valid      (out_valid),
        .out_idx        (out_idx),
        .out_ready      (out_ready),
        .done           (done),
        .any_resp       (any_resp),
        .first_idx      (first_idx)
`ifdef CAPP_RESP_COUNT_EN
        ,
        .resp_count     (resp_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference responder set, one bit per word.
    logic [N-1:0] m_tags;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] gen_mm(input int zero_one_in);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i] = ($urandom_range(zero_one_in - 1) != 0);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_ovalid"}, out_valid, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_any"}, any_resp, (m_tags != '0));
        check({tag, "_first"}, first_idx, lowest(m_tags));
`ifdef CAPP_RESP_COUNT_EN
        check({tag, "_count"}, resp_count, $countones(m_tags));
`endif
    endtask

    task automatic do_clear();
        cmd_valid = 1'b1;
        cmd       = CMD_CLEAR;
        check("clr_accept", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        m_tags    = '0;
        check_idle("clr");
    endtask

    task automatic do_sample(input logic is_and, input logic [N-1:0] mm);
        cmd_valid      = 1'b1;
        cmd            = is_and ? CMD_AND : CMD_LOAD;
        mismatch_lines = gen_mm(2);
        check("smp_accept", cmd_ready, 1'b1);
        step();
        // Stray commands while busy must be ignored.
        cmd_valid      = 1'($urandom_range(1));
        cmd            = 2'($urandom_range(3));
        mismatch_lines = mm;
        check("smp_busy", cmd_ready, 1'b0);
        check("smp_ovalid", out_valid, 1'b0);
        check("smp_any_old", any_resp, (m_tags != '0));
        step();
        cmd_valid      = 1'b0;
        mismatch_lines = gen_mm(2);
        m_tags         = is_and ? (m_tags & ~mm) : ~mm;
        check_idle(is_and ? "and" : "load");
    endtask

    task automatic do_enum(input bit random_ready);
        int  q[$];
        bit  finished = 0;
        bit  hs;
        for (int i = 0; i < N; i++) begin
            if (m_tags[i]) q.push_back(i);
        end
        cmd_valid = 1'b1;
        cmd       = CMD_ENUM;
        out_ready = 1'b1;
        check("enum_accept", cmd_ready, 1'b1);
        step();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            cmd_valid = 1'($urandom_range(1));
            cmd       = 2'($urandom_range(3));
            check("enum_busy", cmd_ready, 1'b0);
            check("enum_ovalid", out_valid, (q.size() != 0));
            check("enum_done", done, (q.size() == 0));
            check("enum_any", any_resp, (q.size() != 0));
            if (q.size() != 0) begin
                check("enum_idx", out_idx, q[0]);
                check("enum_first", first_idx, q[0]);
`ifdef CAPP_RESP_COUNT_EN
                check("enum_count", resp_count, q.size());
`endif
            end
            if (q.size() == 0) begin
                finished = 1;
                break;
            end
            out_ready = random_ready ? 1'($urandom_range(1)) : 1'b1;
            hs        = out_ready;
            step();
            if (hs) void'(q.pop_front());
        end
        if (!finished) check("enum_timeout", 1'b0, 1'b1);
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        step();
        m_tags = '0;
        check_idle("enum_end");
    endtask

    initial begin
        logic [N-1:0] mm;
        int r;

        cmd_valid      = 1'b0;
        cmd            = CMD_CLEAR;
        out_ready      = 1'b0;
        mismatch_lines = '1;
        m_tags         = '0;
        #12;
        check_idle("reset");
        check("reset_idx", out_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle("post_reset");

        // Bits 1 and 4 respond, then intersect with bits 2,3,4.
        mm = '1; mm[1] = 1'b0; mm[4] = 1'b0;
        do_sample(1'b0, mm);
        mm = '1; mm[2] = 1'b0; mm[3] = 1'b0; mm[4] = 1'b0;
        do_sample(1'b1, mm);

        // Includes the top word.
        mm = '1; mm[1] = 1'b0; mm[4] = 1'b0; mm[N-1] = 1'b0;
        do_sample(1'b0, mm);
        do_enum(1'b0);

        do_sample(1'b0, gen_mm(8));
        do_enum(1'b1);

        do_clear();
        do_enum(1'b0);

        // Reset in the middle of an enumeration.
        mm = '1; mm[1] = 1'b0; mm[4] = 1'b0; mm[N-1] = 1'b0;
        do_sample(1'b0, mm);
        cmd_valid = 1'b1;
        cmd       = CMD_ENUM;
        out_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("rst_pre_idx", out_idx, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        m_tags = '0;
        check_idle("mid_rst");
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_done", done, 1'b0);
            check("mid_rst_ovalid", out_valid, 1'b0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        step();
        check_idle("rst_release");

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(9);
            if (r == 0) begin
                do_clear();
            end else if (r <= 3) begin
                do_sample(1'b0, ($urandom_range(7) == 0) ? '1 : gen_mm(10));
            end else if (r <= 6) begin
                do_sample(1'b1, gen_mm(4));
            end else begin
                do_enum(1'($urandom_range(1)));
            end
            if ($urandom_range(3) == 0) begin
                step();
                check_idle("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_capp_response_resolver

`default_nettype wire
